memory_stage: RTL and testbench
===============================

# memory_stage

Pipeline M stage between execute and `writeback`. It takes the ALU result, store data and control bundle from execute and drives a variable-latency data-memory port through a req/ack handshake. It stalls execute while an access is outstanding and registers the MEM/WB bundle (`o`, `d`, `insn`, `aluop`, `rwe`, `rdst`, `rwd`) consumed by `writeback`. Byte loads are delivered with the selected byte aligned to `d[31:24]`.

## Interface
- `TIMEOUT_CYCLES`, 16: max cycles `dm_req` is held without `dm_ack` before abort (≥2)
- `CNT_W`, 5: timeout counter width; must hold `TIMEOUT_CYCLES`

Ports:
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high; all state/outputs cleared at the edge where sampled high
- `ex_valid`  in  1  execute presents a valid insn
- `ex_o`  in  32  ALU result / effective address
- `ex_b`  in  32  store data (rt)
- `ex_insn`  in  32  instruction word
- `ex_aluop`  in  6  ALU opcode
- `ex_dmwe`, `ex_rwe`, `ex_rdst`, `ex_rwd`, `ex_dm_byte`  in  1 each  control bits
- `m_stall`  out  1  hold execute; combinational, = (state != IDLE)
- `dm_req`  out  1  memory request, registered
- `dm_we`  out  1  write request
- `dm_addr`  out  32  word-aligned address (`ex_o` with [1:0] cleared)
- `dm_wdata`  out  32  store data, lane-positioned
- `dm_be`  out  4  byte enables; `dm_be[3]` = lane [31:24]
- `dm_rdata`  in  32  read data, valid with `dm_ack`
- `dm_ack`  in  1  one-cycle completion
- `wb_valid`  out  1  MEM/WB bundle valid
- `wb_o`  out  32  registered `ex_o` (PC+8 for JAL/JALR)
- `wb_d`  out  32  load data
- `wb_insn`  out  32
- `wb_aluop`  out  6
- `wb_rwe`, `wb_rdst`, `wb_rwd`  out  1 each; `wb_rwe` is 0 whenever `wb_valid` = 0
- `bus_err`  out  1  one-cycle pulse on timeout or misalignment

## Operation
- Memory op = `ex_dmwe` or `ex_rwd`. Big-endian: byte address offset 0 maps to [31:24].
- States: IDLE, REQ. IDLE, `ex_valid` && memory op && aligned → latch bundle, `dm_req`=1, REQ. IDLE, non-memory op → bundle straight to MEM/WB, `wb_valid`=1 next edge.
- Alignment: word op (`ex_dm_byte`=0) requires `ex_o[1:0]`==0. A misaligned op issues no request; it produces `wb_valid`=1, `wb_rwe`=0, `bus_err` pulse.
- Store word: `dm_be`=4'b1111, `dm_wdata`=`ex_b`. Store byte: `dm_be` one-hot at lane `3-ex_o[1:0]`; `dm_wdata` = `ex_b[7:0]` replicated on all lanes.
- Load: `wb_d` = `dm_rdata` for word loads. For byte loads (`LB_OP`, `LBU_OP`), `wb_d[31:24]` = selected lane and `wb_d[23:0]` = 0; extension is done in writeback.
- REQ: `dm_req`, `dm_we`, `dm_addr`, `dm_wdata`, `dm_be` held stable. On `dm_ack`: capture load data, `dm_req`=0, `wb_valid`=1, → IDLE.
- Counter counts REQ cycles. If it reaches `TIMEOUT_CYCLES` without ack: `dm_req`=0, `bus_err` pulse, `wb_valid`=1 with `wb_rwe`=0, → IDLE.
- `dm_ack` and timeout in the same cycle: ack wins, no `bus_err`.
- `dm_ack` while in IDLE is ignored.
- `ex_valid`=0 in IDLE → `wb_valid`=0 (bubble).

## Timing
- Reset values: state IDLE; `dm_req`, `dm_we`, `dm_be`, `wb_valid`, `wb_rwe`, `wb_rdst`, `wb_rwd`, `bus_err` = 0; all 32-bit and 6-bit outputs = 0.
- Non-memory op: 1-cycle latency, accepted at edge T, `wb_*` valid after T.
- Memory op: accepted at T, `dm_req` high from T. Ack sampled at edge T+k (k≥1) gives `wb_valid` after T+k. Total latency k+1; `m_stall` high for k cycles.
- While `m_stall`=1, execute inputs are ignored and must be held. `wb_valid`=0 during REQ.
- Reset asserted during REQ: `dm_req` low after that edge, in-flight op discarded, no `bus_err`. A late `dm_ack` is ignored.

## Structure
- Shared package `mips_pkg`: opcodes `LB_OP`=6'b010101, `LBU_OP`=6'b011000, `LW_OP`=6'b010100, `SW_OP`=6'b010110, `SB_OP`=6'b010111, `JAL_OP`=6'b100000, `JALR_OP`=6'b010001; M-stage state enum.
- One combinational sub-module `dmem_lane`: `dm_be`/`dm_wdata` generation from offset, size and store data, plus load-byte alignment to [31:24].
- FSM, timeout counter and MEM/WB register live in `memory_stage`.

## Test plan
- ADD, `ex_o`=32'h0000_0010 → next cycle `wb_valid`=1, `wb_o`=32'h10, no `dm_req`, `m_stall`=0.
- LW addr 32'h100, ack after 3 cycles with `dm_rdata`=32'hDEAD_BEEF → `m_stall` high 3 cycles, then `wb_d`=32'hDEAD_BEEF.
- SB addr 32'h203, `ex_b`=32'h0000_00A5 → `dm_be`=4'b0001, `dm_addr`=32'h200, `dm_wdata`=32'hA5A5_A5A5.
- LB addr 32'h101, `dm_rdata`=32'h11_F2_33_44 → `wb_d`=32'hF200_0000.
- LW with no ack (`TIMEOUT_CYCLES`=4) → `dm_req` drops after 4 cycles, `bus_err` pulses, `wb_rwe`=0. Repeat with ack on cycle 4 → no `bus_err`.
- Reset during REQ → `dm_req`=0 next cycle, all outputs zero, later `dm_ack` ignored. LW addr 32'h102 → no request, `bus_err` pulse.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: opcodes and M-stage state shared across the pipeline
package mips_pkg;

    localparam logic [5:0] LB_OP   = 6'b010101;
    localparam logic [5:0] LBU_OP  = 6'b011000;
    localparam logic [5:0] LW_OP   = 6'b010100;
    localparam logic [5:0] SW_OP   = 6'b010110;
    localparam logic [5:0] SB_OP   = 6'b010111;
    localparam logic [5:0] JAL_OP  = 6'b100000;
    localparam logic [5:0] JALR_OP = 6'b010001;

    typedef enum logic {IDLE, REQ} mstate_t;

endpackage

// File: rtl/dmem_lane.sv
// dmem_lane: big-endian byte-lane steering for stores and byte-load alignment
module dmem_lane (
    input  logic [1:0]  off_i,
    input  logic        byte_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] rshift;

    // offset 0 is lane [31:24], so the lane index is the inverted offset
    always_comb begin
        be_o    = byte_i ? 4'b1000 >> off_i : 4'b1111;
        wdata_o = byte_i ? {4{wdata_i[7:0]}} : wdata_i;
        rshift  = rdata_i >> {~off_i, 3'b000};
        rdata_o = byte_i ? {rshift[7:0], 24'h0} : rdata_i;
    end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: M pipeline stage, drives a req/ack data-memory port and the MEM/WB register
module memory_stage
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [31:0] ex_o,
    input  logic [31:0] ex_b,
    input  logic [31:0] ex_insn,
    input  logic [5:0]  ex_aluop,
    input  logic        ex_dmwe,
    input  logic        ex_rwe,
    input  logic        ex_rdst,
    input  logic        ex_rwd,
    input  logic        ex_dm_byte,
    output logic        m_stall,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_be,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        wb_valid,
    output logic [31:0] wb_o,
    output logic [31:0] wb_d,
    output logic [31:0] wb_insn,
    output logic [5:0]  wb_aluop,
    output logic        wb_rwe,
    output logic        wb_rdst,
    output logic        wb_rwd,
    output logic        bus_err
);

    mstate_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             mem_op, aligned, accept, timeout, done;
    logic [1:0]       lane_off;
    logic             lane_byte;
    logic [3:0]       lane_be;
    logic [31:0]      lane_wdata, lane_rdata;
    logic [31:0]      req_o_q, req_insn_q;
    logic [5:0]       req_aluop_q;
    logic             req_rwe_q, req_rdst_q, req_rwd_q, req_byte_q;
    logic             dm_req_q, dm_we_q, bus_err_q;
    logic [31:0]      dm_addr_q, dm_wdata_q;
    logic [3:0]       dm_be_q;
    logic             wb_valid_q, wb_rwe_q, wb_rdst_q, wb_rwd_q;
    logic [31:0]      wb_o_q, wb_d_q, wb_insn_q;
    logic [5:0]       wb_aluop_q;

    // decode of the execute bundle and completion events of an outstanding access
    always_comb begin
        mem_op    = ex_dmwe || ex_rwd;
        aligned   = ex_dm_byte || ex_o[1:0] == 2'b00;
        accept    = ex_valid && mem_op && aligned;
        timeout   = cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
        done      = dm_ack || timeout;
        lane_off  = state_q == REQ ? req_o_q[1:0] : ex_o[1:0];
        lane_byte = state_q == REQ ? req_byte_q : ex_dm_byte;
    end

    dmem_lane u_lane (
        .off_i   (lane_off),
        .byte_i  (lane_byte),
        .wdata_i (ex_b),
        .rdata_i (dm_rdata),
        .be_o    (lane_be),
        .wdata_o (lane_wdata),
        .rdata_o (lane_rdata)
    );

    // state register
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // next state: IDLE waits for an aligned memory op, REQ waits for ack or timeout
    always_comb begin
        state_d = state_q == IDLE ? (accept ? REQ : IDLE) : (done ? IDLE : REQ);
    end

    // stall execute for every cycle an access is outstanding
    always_comb begin
        m_stall = state_q != IDLE;
    end

    // memory port, timeout counter, in-flight bundle and MEM/WB register
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q       <= '0;
            req_o_q     <= '0;
            req_insn_q  <= '0;
            req_aluop_q <= '0;
            req_rwe_q   <= 1'b0;
            req_rdst_q  <= 1'b0;
            req_rwd_q   <= 1'b0;
            req_byte_q  <= 1'b0;
            dm_req_q    <= 1'b0;
            dm_we_q     <= 1'b0;
            dm_addr_q   <= '0;
            dm_wdata_q  <= '0;
            dm_be_q     <= '0;
            bus_err_q   <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_rwe_q    <= 1'b0;
            wb_rdst_q   <= 1'b0;
            wb_rwd_q    <= 1'b0;
            wb_o_q      <= '0;
            wb_d_q      <= '0;
            wb_insn_q   <= '0;
            wb_aluop_q  <= '0;
        end else begin
            bus_err_q <= 1'b0;
            if (state_q == IDLE) begin
                wb_valid_q <= ex_valid && !accept;
                wb_rwe_q   <= ex_valid && !mem_op && ex_rwe;
                if (ex_valid) begin
                    wb_o_q     <= ex_o;
                    wb_d_q     <= '0;
                    wb_insn_q  <= ex_insn;
                    wb_aluop_q <= ex_aluop;
                    wb_rdst_q  <= ex_rdst;
                    wb_rwd_q   <= ex_rwd;
                    bus_err_q  <= mem_op && !aligned;
                end
                if (accept) begin
                    cnt_q       <= '0;
                    dm_req_q    <= 1'b1;
                    dm_we_q     <= ex_dmwe;
                    dm_addr_q   <= {ex_o[31:2], 2'b00};
                    dm_wdata_q  <= lane_wdata;
                    dm_be_q     <= lane_be;
                    req_o_q     <= ex_o;
                    req_insn_q  <= ex_insn;
                    req_aluop_q <= ex_aluop;
                    req_rwe_q   <= ex_rwe;
                    req_rdst_q  <= ex_rdst;
                    req_rwd_q   <= ex_rwd;
                    req_byte_q  <= ex_dm_byte;
                end
            end else if (done) begin
                dm_req_q   <= 1'b0;
                dm_we_q    <= 1'b0;
                dm_be_q    <= '0;
                bus_err_q  <= !dm_ack;
                wb_valid_q <= 1'b1;
                wb_rwe_q   <= dm_ack && req_rwe_q;
                wb_o_q     <= req_o_q;
                wb_d_q     <= dm_ack ? lane_rdata : '0;
                wb_insn_q  <= req_insn_q;
                wb_aluop_q <= req_aluop_q;
                wb_rdst_q  <= req_rdst_q;
                wb_rwd_q   <= req_rwd_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign dm_req   = dm_req_q;
    assign dm_we    = dm_we_q;
    assign dm_addr  = dm_addr_q;
    assign dm_wdata = dm_wdata_q;
    assign dm_be    = dm_be_q;
    assign bus_err  = bus_err_q;
    assign wb_valid = wb_valid_q;
    assign wb_o     = wb_o_q;
    assign wb_d     = wb_d_q;
    assign wb_insn  = wb_insn_q;
    assign wb_aluop = wb_aluop_q;
    assign wb_rwe   = wb_rwe_q;
    assign wb_rdst  = wb_rdst_q;
    assign wb_rwd   = wb_rwd_q;

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed and random transactions against a transaction-level model
module tb_memory_stage;
    import mips_pkg::*;

    localparam int TO = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_o = '0, ex_b = '0, ex_insn = '0;
    logic [5:0]  ex_aluop = '0;
    logic        ex_dmwe = 1'b0, ex_rwe = 1'b0, ex_rdst = 1'b0, ex_rwd = 1'b0, ex_dm_byte = 1'b0;
    logic        m_stall, dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic [3:0]  dm_be;
    logic [31:0] dm_rdata = '0;
    logic        dm_ack = 1'b0;
    logic        wb_valid, wb_rwe, wb_rdst, wb_rwd, bus_err;
    logic [31:0] wb_o, wb_d, wb_insn;
    logic [5:0]  wb_aluop;
    int          n_chk = 0, n_fail = 0;

    memory_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(3)) dut (
        .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_o(ex_o), .ex_b(ex_b),
        .ex_insn(ex_insn), .ex_aluop(ex_aluop), .ex_dmwe(ex_dmwe), .ex_rwe(ex_rwe),
        .ex_rdst(ex_rdst), .ex_rwd(ex_rwd), .ex_dm_byte(ex_dm_byte), .m_stall(m_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack), .wb_valid(wb_valid), .wb_o(wb_o), .wb_d(wb_d),
        .wb_insn(wb_insn), .wb_aluop(wb_aluop), .wb_rwe(wb_rwe), .wb_rdst(wb_rdst),
        .wb_rwd(wb_rwd), .bus_err(bus_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // one transaction; k = cycle of ack after acceptance (k > TO means no ack)
    task automatic do_op(input logic v, input logic [5:0] op, input logic we, input logic rd,
                         input logic by, input logic rwe, input logic [31:0] o, input logic [31:0] b,
                         input int k, input logic [31:0] rdata);
        logic        mem, ok, rdst;
        logic [31:0] insn, exp_d;
        int          offs;
        mem   = we || rd;
        ok    = by || o[1:0] == 2'b00;
        offs  = int'(o[1:0]);
        rdst  = 1'($urandom);
        insn  = $urandom;
        exp_d = by ? ((rdata >> (8 * (3 - offs))) & 32'hFF) << 24 : rdata;
        chk("idle_stall", 32'(m_stall), 0);
        ex_valid = v; ex_aluop = op; ex_dmwe = we; ex_rwd = rd; ex_dm_byte = by;
        ex_rwe = rwe; ex_rdst = rdst; ex_o = o; ex_b = b; ex_insn = insn;
        tick;
        if (!(v && mem && ok)) begin
            chk("nm_valid", 32'(wb_valid), 32'(v));
            chk("nm_req", 32'(dm_req), 0);
            chk("nm_stall", 32'(m_stall), 0);
            chk("nm_err", 32'(bus_err), 32'(v && mem));
            chk("nm_rwe", 32'(wb_rwe), 32'(v && !mem && rwe));
            if (v) begin
                chk("nm_o", wb_o, o);
                chk("nm_insn", wb_insn, insn);
                chk("nm_aluop", 32'(wb_aluop), 32'(op));
                chk("nm_rdst", 32'(wb_rdst), 32'(rdst));
            end
            ex_valid = 1'b0;
            return;
        end
        chk("acc_req", 32'(dm_req), 1);
        chk("acc_stall", 32'(m_stall), 1);
        chk("acc_we", 32'(dm_we), 32'(we));
        chk("acc_addr", dm_addr, o & ~32'h3);
        chk("acc_wbv", 32'(wb_valid), 0);
        if (we) begin
            chk("acc_be", 32'(dm_be), by ? 32'(1 << (3 - offs)) : 32'hF);
            chk("acc_wdata", dm_wdata, by ? {4{b[7:0]}} : b);
        end
        for (int j = 1; j <= TO; j++) begin
            dm_ack   = (j == k);
            dm_rdata = dm_ack ? rdata : $urandom;
            tick;
            dm_ack = 1'b0;
            if (j == k || j == TO) begin
                chk("done_req", 32'(dm_req), 0);
                chk("done_stall", 32'(m_stall), 0);
                chk("done_valid", 32'(wb_valid), 1);
                chk("done_err", 32'(bus_err), 32'(j != k));
                chk("done_rwe", 32'(wb_rwe), 32'(j == k && rwe));
                chk("done_o", wb_o, o);
                chk("done_insn", wb_insn, insn);
                chk("done_rdst", 32'(wb_rdst), 32'(rdst));
                if (j == k && rd) chk("done_d", wb_d, exp_d);
                break;
            end
            chk("req_hold", 32'(dm_req), 1);
            chk("req_stall", 32'(m_stall), 1);
            chk("req_addr", dm_addr, o & ~32'h3);
            chk("req_wbv", 32'(wb_valid), 0);
        end
        ex_valid = 1'b0;
        tick;
        chk("post_err", 32'(bus_err), 0);
    endtask

    initial begin
        tick;
        tick;
        chk("rst_req", 32'(dm_req), 0);
        chk("rst_stall", 32'(m_stall), 0);
        chk("rst_wbv", 32'(wb_valid), 0);
        chk("rst_o", wb_o, 0);
        chk("rst_be", 32'(dm_be), 0);
        chk("rst_err", 32'(bus_err), 0);
        reset = 1'b0;
        tick;
        do_op(1, 6'h01, 0, 0, 0, 1, 32'h10, 32'h0, 0, 32'h0);
        do_op(1, LW_OP, 0, 1, 0, 1, 32'h100, 32'h0, 3, 32'hDEAD_BEEF);
        do_op(1, SB_OP, 1, 0, 1, 0, 32'h203, 32'hA5, 2, 32'h0);
        do_op(1, LB_OP, 0, 1, 1, 1, 32'h101, 32'h0, 1, 32'h11F2_3344);
        do_op(1, LW_OP, 0, 1, 0, 1, 32'h140, 32'h0, TO + 1, 32'h0);
        do_op(1, LW_OP, 0, 1, 0, 1, 32'h144, 32'h0, TO, 32'h1234_5678);
        do_op(1, LW_OP, 0, 1, 0, 1, 32'h102, 32'h0, 1, 32'h0);
        ex_valid = 1'b1; ex_rwd = 1'b1; ex_dmwe = 1'b0; ex_dm_byte = 1'b0; ex_rwe = 1'b1;
        ex_o = 32'h300; ex_aluop = LW_OP;
        tick;
        chk("rr_req", 32'(dm_req), 1);
        tick;
        reset = 1'b1;
        tick;
        chk("rr_req0", 32'(dm_req), 0);
        chk("rr_stall", 32'(m_stall), 0);
        chk("rr_wbv", 32'(wb_valid), 0);
        chk("rr_o", wb_o, 0);
        chk("rr_addr", dm_addr, 0);
        chk("rr_err", 32'(bus_err), 0);
        reset = 1'b0;
        ex_valid = 1'b0;
        dm_ack = 1'b1;
        tick;
        dm_ack = 1'b0;
        chk("late_wbv", 32'(wb_valid), 0);
        chk("late_req", 32'(dm_req), 0);
        chk("late_err", 32'(bus_err), 0);
        for (int i = 0; i < 80; i++) begin
            int          kind, k;
            logic [31:0] a, b;
            kind = $urandom_range(0, 5);
            k    = $urandom_range(1, TO + 1);
            a    = $urandom;
            b    = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            case (kind)
                0: do_op(1, JAL_OP, 0, 0, 0, 1'($urandom), a, b, k, $urandom);
                1: do_op(0, 6'h01, 0, 0, 0, 1, a, b, k, $urandom);
                2: do_op(1, LW_OP, 0, 1, 0, 1, a, b, k, $urandom);
                3: do_op(1, LBU_OP, 0, 1, 1, 1, a, b, k, $urandom);
                4: do_op(1, SW_OP, 1, 0, 0, 0, a, b, k, $urandom);
                default: do_op(1, SB_OP, 1, 0, 1, 0, a, b, k, $urandom);
            endcase
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
